alien_wave_ctrl: RTL and testbench

Wave scheduler for the alien array: sequences spawning of `NUM_ALIENS` alien instances one at a time on frame ticks, tracks which slots are alive, accumulates score from hits, advances waves and detects game over on any out-of-bounds alien. Sits between the game top level and the alien instances. It drives each alien's load/reset and shared start-position bus, and consumes each alien's hit and out-of-bounds flags.

---
 rtl/alien_ctrl_pkg.sv | 22 ++
 rtl/frame_tick.sv | 28 ++
 rtl/alien_wave_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alien_wave_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alien_ctrl_pkg.sv
// Shared types and helpers for the alien wave scheduler and its companions.
package alien_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_PLAY,
    ST_CLEAR,
    ST_GAME_OVER
  } wave_state_t;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
  localparam logic [3:0]  WAVE_MAX  = 4'd15;

  // Start x of a slot on the 10-bit playfield coordinate bus.
  function automatic logic [9:0] slot_x(input int i, input int x_base = 40, input int x_pitch = 64);
    int v;
    v = x_base + x_pitch * i;
    return v[9:0];
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Two-flop synchronizer for the asynchronous frame strobe, with a registered
// one-cycle pulse on each rising edge (3 clocks from strobe edge to pulse).
module frame_tick (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_clk,
  output logic o_tick
);

  logic r_sync1, r_sync2, r_sync3, r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/alien_wave_ctrl.sv
// Wave scheduler: spawns alien slots on frame ticks, scores hits, advances
// waves and ends the game when any live alien goes out of bounds.
//   state        | meaning
//   ST_IDLE      | after reset, waiting for start
//   ST_SPAWN     | loading slots one per SPAWN_FRAMES ticks, hits/oob live
//   ST_PLAY      | all slots loaded, waiting for wave clear or oob
//   ST_CLEAR     | pause of CLEAR_FRAMES ticks before the next wave
//   ST_GAME_OVER | alive cleared, score/wave frozen until start
module alien_wave_ctrl
  import alien_ctrl_pkg::*;
#(
  parameter int NUM_ALIENS   = 8,
  parameter int SPAWN_FRAMES = 30,
  parameter int CLEAR_FRAMES = 60,
  parameter int X_BASE       = 40,
  parameter int X_PITCH      = 64,
  parameter int Y_START      = 20,
  parameter int HIT_POINTS   = 10
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic                  start,
  input  logic [NUM_ALIENS-1:0] alien_hit,
  input  logic [NUM_ALIENS-1:0] alien_oob,
  output logic [NUM_ALIENS-1:0] alien_load,
  output logic [9:0]            alien_x_start,
  output logic [9:0]            alien_y_start,
  output logic                  alien_dir,
  output logic [NUM_ALIENS-1:0] alive,
  output logic [15:0]           score,
  output logic [3:0]            wave,
  output logic                  playing,
  output logic                  game_over
);

  localparam int SLOT_W  = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
  localparam int CNT_MAX = (SPAWN_FRAMES > CLEAR_FRAMES) ? SPAWN_FRAMES : CLEAR_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PC_W    = $clog2(NUM_ALIENS + 1);

  wave_state_t           r_state, w_state_nxt;
  logic [SLOT_W-1:0]     r_slot, w_slot_nxt;
  logic [CNT_W-1:0]      r_frame_cnt, w_frame_cnt_nxt;
  logic [NUM_ALIENS-1:0] r_alive, w_alive_nxt;
  logic [NUM_ALIENS-1:0] r_load, w_load_nxt;
  logic [9:0]            r_x, w_x_nxt, r_y, w_y_nxt;
  logic                  r_dir, w_dir_nxt;
  logic [15:0]           r_score, w_score_nxt;
  logic [3:0]            r_wave, w_wave_nxt;
  logic                  r_playing, r_game_over;

  logic                  w_tick;
  logic                  w_active;
  logic [NUM_ALIENS-1:0] w_hits, w_oob, w_load_sel;
  logic [PC_W-1:0]       w_hit_cnt;
  logic [31:0]           w_score_sum;
  logic [15:0]           w_score_hit;

  frame_tick u_frame_tick (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_frame_clk (frame_clk),
    .o_tick      (w_tick)
  );

  // A slot whose load pulse is out this cycle is being reset, so its stale
  // flags from the previous life are masked.
  always_comb begin
    w_active  = (r_state == ST_SPAWN) || (r_state == ST_PLAY);
    w_hits    = w_active ? (r_alive & alien_hit & ~r_load) : '0;
    w_oob     = w_active ? (r_alive & alien_oob & ~r_load) : '0;
    w_hit_cnt = '0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      w_hit_cnt = w_hit_cnt + PC_W'(w_hits[i]);
      w_load_sel[i] = (r_slot == SLOT_W'(i));
    end
    w_score_sum = 32'(r_score) + 32'(HIT_POINTS) * 32'(w_hit_cnt);
    w_score_hit = (w_score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[15:0];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_frame_cnt_nxt = r_frame_cnt;
    w_alive_nxt     = r_alive;
    w_load_nxt      = '0;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_dir_nxt       = r_dir;
    w_score_nxt     = r_score;
    w_wave_nxt      = r_wave;

    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          w_state_nxt     = ST_SPAWN;
          w_slot_nxt      = '0;
          w_frame_cnt_nxt = '0;
          w_score_nxt     = '0;
          w_wave_nxt      = '0;
        end
      end

      ST_SPAWN: begin
        w_alive_nxt = r_alive & ~w_hits;
        w_score_nxt = w_score_hit;
        if (|w_oob) begin
          w_state_nxt = ST_GAME_OVER;
          w_alive_nxt = '0;
        end else if (w_tick) begin
          if (r_frame_cnt == '0) begin
            w_load_nxt      = w_load_sel;
            w_alive_nxt     = w_alive_nxt | w_load_sel;
            w_x_nxt         = slot_x(32'(r_slot), X_BASE, X_PITCH);
            w_y_nxt         = 10'(Y_START);
            w_dir_nxt       = ~r_slot[0];
            w_frame_cnt_nxt = CNT_W'(SPAWN_FRAMES - 1);
            if (r_slot == SLOT_W'(NUM_ALIENS - 1)) w_state_nxt = ST_PLAY;
            else                                    w_slot_nxt  = r_slot + SLOT_W'(1);
          end else begin
            w_frame_cnt_nxt = r_frame_cnt - CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        w_alive_nxt = r_alive & ~w_hits;
        w_score_nxt = w_score_hit;
        if (|w_oob) begin
          w_state_nxt = ST_GAME_OVER;
          w_alive_nxt = '0;
        end else if (r_alive == '0) begin
          w_state_nxt     = ST_CLEAR;
          w_frame_cnt_nxt = '0;
        end
      end

      ST_CLEAR: begin
        if (w_tick) begin
          if (r_frame_cnt == CNT_W'(CLEAR_FRAMES - 1)) begin
            w_state_nxt     = ST_SPAWN;
            w_slot_nxt      = '0;
            w_frame_cnt_nxt = '0;
            if (r_wave != WAVE_MAX) w_wave_nxt = r_wave + 4'd1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_frame_cnt <= '0;
      r_alive     <= '0;
      r_load      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dir       <= 1'b0;
      r_score     <= '0;
      r_wave      <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_alive     <= w_alive_nxt;
      r_load      <= w_load_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dir       <= w_dir_nxt;
      r_score     <= w_score_nxt;
      r_wave      <= w_wave_nxt;
      r_playing   <= (r_state == ST_SPAWN) || (r_state == ST_PLAY) || (r_state == ST_CLEAR);
      r_game_over <= (r_state == ST_GAME_OVER);
    end
  end

  assign alien_load    = r_load;
  assign alien_x_start = r_x;
  assign alien_y_start = r_y;
  assign alien_dir     = r_dir;
  assign alive         = r_alive;
  assign score         = r_score;
  assign wave          = r_wave;
  assign playing       = r_playing;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_alien_wave_ctrl.sv
// Directed bench for alien_wave_ctrl: load scoreboard plus inline checks of
// alive/score/wave/flags through spawn, hits, clear, oob, saturation, reset.
module tb_alien_wave_ctrl;

  localparam int N  = 4;
  localparam int HP = 13105;  // 5 hits land exactly on 16'hFFF5

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         frame_clk = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] alien_hit = '0;
  logic [N-1:0] alien_oob = '0;
  logic [N-1:0] alien_load;
  logic [9:0]   alien_x_start, alien_y_start;
  logic         alien_dir;
  logic [N-1:0] alive;
  logic [15:0]  score;
  logic [3:0]   wave;
  logic         playing, game_over;

  alien_wave_ctrl #(
    .NUM_ALIENS(N), .SPAWN_FRAMES(2), .CLEAR_FRAMES(3),
    .X_BASE(40), .X_PITCH(64), .Y_START(20), .HIT_POINTS(HP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .alien_hit(alien_hit), .alien_oob(alien_oob), .alien_load(alien_load),
    .alien_x_start(alien_x_start), .alien_y_start(alien_y_start), .alien_dir(alien_dir),
    .alive(alive), .score(score), .wave(wave), .playing(playing), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [N-1:0] load;
    logic [9:0]   x;
    logic [9:0]   y;
    logic         dir;
  } load_t;

  load_t exp_q[$];
  load_t mon_e;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input int i);
    load_t e;
    e.load    = '0;
    e.load[i] = 1'b1;
    e.x       = 10'(40 + 64 * i);
    e.y       = 10'd20;
    e.dir     = (i % 2 == 0);
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    cycles(4);
    frame_clk = 1'b0;
    cycles(4);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && alien_load !== '0) begin
      if (exp_q.size() == 0) begin
        chk("load_unexpected", 32'(alien_load), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("load_slot", 32'(alien_load), 32'(mon_e.load));
        chk("load_x",    32'(alien_x_start), 32'(mon_e.x));
        chk("load_y",    32'(alien_y_start), 32'(mon_e.y));
        chk("load_dir",  32'(alien_dir), 32'(mon_e.dir));
      end
    end
  end

  initial begin
    cycles(2);
    chk("rst_load",  32'(alien_load), 32'd0);
    chk("rst_x",     32'(alien_x_start), 32'd0);
    chk("rst_alive", 32'(alive), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_wave",  32'(wave), 32'd0);
    chk("rst_play",  32'(playing), 32'd0);
    chk("rst_go",    32'(game_over), 32'd0);
    Reset_n = 1'b1;
    cycles(2);

    // game 1, wave 0
    start = 1'b1; cycles(1); start = 1'b0; cycles(2);
    chk("start_playing", 32'(playing), 32'd1);
    for (int i = 0; i < N; i++) push_load(i);
    repeat (7) frame_pulse();
    cycles(2);
    chk("spawn_alive", 32'(alive), 32'hF);
    chk("spawn_q",     32'(exp_q.size()), 32'd0);
    chk("bus_hold_x",  32'(alien_x_start), 32'd232);
    chk("bus_hold_dir", 32'(alien_dir), 32'd0);

    alien_hit = 4'b0101; cycles(1);
    chk("hit1_alive", 32'(alive), 32'hA);
    chk("hit1_score", 32'(score), 32'd26210);
    cycles(2);
    chk("hit1_hold_score", 32'(score), 32'd26210);
    alien_hit = 4'b1010; cycles(1); alien_hit = '0;
    chk("hit2_alive", 32'(alive), 32'h0);
    chk("hit2_score", 32'(score), 32'd52420);
    cycles(3);
    chk("clear_playing", 32'(playing), 32'd1);

    // clear pause then wave 1 respawn
    for (int i = 0; i < N; i++) push_load(i);
    repeat (3) frame_pulse();
    chk("clear_wave", 32'(wave), 32'd1);
    chk("clear_no_load", 32'(exp_q.size()), 32'd4);
    repeat (7) frame_pulse();
    cycles(2);
    chk("w1_alive", 32'(alive), 32'hF);
    chk("w1_q", 32'(exp_q.size()), 32'd0);

    alien_hit = 4'b0001; cycles(1); alien_hit = '0;
    chk("pre_sat_score", 32'(score), 32'hFFF5);
    chk("pre_sat_alive", 32'(alive), 32'hE);
    alien_oob = 4'b0001; cycles(3); alien_oob = '0;
    chk("oob_dead_go",    32'(game_over), 32'd0);
    chk("oob_dead_alive", 32'(alive), 32'hE);
    chk("oob_dead_play",  32'(playing), 32'd1);
    alien_hit = 4'b0110; cycles(1); alien_hit = '0;
    chk("sat_score", 32'(score), 32'hFFFF);
    chk("sat_alive", 32'(alive), 32'h8);
    alien_oob = 4'b1000; cycles(1); alien_oob = '0;
    chk("oob_alive", 32'(alive), 32'h0);
    cycles(1);
    chk("oob_go",    32'(game_over), 32'd1);
    chk("oob_play",  32'(playing), 32'd0);
    chk("oob_score", 32'(score), 32'hFFFF);
    chk("oob_wave",  32'(wave), 32'd1);

    // game 2: oob and hit in the same cycle
    start = 1'b1; cycles(1); start = 1'b0; cycles(2);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_wave",  32'(wave), 32'd0);
    chk("restart_play",  32'(playing), 32'd1);
    chk("restart_go",    32'(game_over), 32'd0);
    for (int i = 0; i < N; i++) push_load(i);
    repeat (7) frame_pulse();
    cycles(2);
    chk("g2_alive", 32'(alive), 32'hF);
    alien_hit = 4'b0001; cycles(1); alien_hit = '0;
    chk("g2_score", 32'(score), 32'd13105);
    alien_oob = 4'b0100; alien_hit = 4'b0010; cycles(1);
    alien_oob = '0; alien_hit = '0;
    chk("oobhit_score", 32'(score), 32'd26210);
    chk("oobhit_alive", 32'(alive), 32'h0);
    cycles(1);
    chk("oobhit_go", 32'(game_over), 32'd1);

    // game 3: asynchronous reset in the middle of spawning
    start = 1'b1; cycles(1); start = 1'b0;
    push_load(0); push_load(1);
    repeat (3) frame_pulse();
    chk("g3_alive", 32'(alive), 32'h3);
    chk("g3_q", 32'(exp_q.size()), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_load",  32'(alien_load), 32'd0);
    chk("arst_x",     32'(alien_x_start), 32'd0);
    chk("arst_y",     32'(alien_y_start), 32'd0);
    chk("arst_dir",   32'(alien_dir), 32'd0);
    chk("arst_alive", 32'(alive), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_wave",  32'(wave), 32'd0);
    chk("arst_play",  32'(playing), 32'd0);
    chk("arst_go",    32'(game_over), 32'd0);
    cycles(2);
    Reset_n = 1'b1;
    cycles(3);
    chk("post_rst_idle", 32'(playing), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
